// File: rtl/sb_pkg.sv
// Shared sideband definitions for the RDI decoder: opcodes, message codes,
// LinkMgmt.RDI subcodes, FSM state encoding and header field helpers.
package sb_pkg;

    localparam logic [4:0] OPC_MSG_NODATA  = 5'b10010;
    localparam logic [4:0] OPC_MSG_DATA    = 5'b11011;

    localparam logic [7:0] MSGCODE_RDI_REQ = 8'h01;
    localparam logic [7:0] MSGCODE_RDI_RSP = 8'h02;

    localparam logic [7:0] SUB_ACTIVE      = 8'h01;
    localparam logic [7:0] SUB_PMNAK       = 8'h02;
    localparam logic [7:0] SUB_L1          = 8'h04;
    localparam logic [7:0] SUB_L2          = 8'h08;
    localparam logic [7:0] SUB_LINKRESET   = 8'h09;
    localparam logic [7:0] SUB_LINKERROR   = 8'h0A;
    localparam logic [7:0] SUB_RETRAIN     = 8'h0B;
    localparam logic [7:0] SUB_DISABLE     = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_DATA = 3'd1,
        ST_HDR_PH0    = 3'd2,
        ST_HDR_PH1    = 3'd3,
        ST_DAT_PH0    = 3'd4,
        ST_DAT_PH1    = 3'd5
    } rdi_dec_state_e;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_RDI     = 3'd1,
        CLS_NODATA  = 3'd2,
        CLS_DATA    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } pkt_class_e;

    function automatic logic [4:0] hdr_opcode(input logic [63:0] word);
        return word[4:0];
    endfunction

    function automatic logic [7:0] hdr_msgcode(input logic [63:0] word);
        return word[21:14];
    endfunction

    function automatic logic [7:0] hdr_subcode(input logic [63:0] word);
        return word[39:32];
    endfunction

    // An RDI message code with a subcode missing from the table is illegal, not NODATA.
    function automatic pkt_class_e classify(input logic       empty,
                                            input logic [4:0] opcode,
                                            input logic [7:0] msgcode,
                                            input logic       lut_hit);
        pkt_class_e cls;
        if (empty) begin
            cls = CLS_NONE;
        end else if (opcode == OPC_MSG_NODATA) begin
            if ((msgcode == MSGCODE_RDI_REQ) || (msgcode == MSGCODE_RDI_RSP)) begin
                cls = lut_hit ? CLS_RDI : CLS_ILLEGAL;
            end else begin
                cls = CLS_NODATA;
            end
        end else if (opcode == OPC_MSG_DATA) begin
            cls = CLS_DATA;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/sb_rdi_msg_lut.sv
// LinkMgmt.RDI {msgcode, subcode} to RDI message number table; the inverse of
// the encoder-side mapping. Requests map to 1..7, responses to 8..15.
module sb_rdi_msg_lut
    import sb_pkg::*;
(
    input  logic [7:0] msgcode,
    input  logic [7:0] subcode,
    output logic       hit,
    output logic [3:0] msg_no
);

    // Table lookup; msg_no is 0 whenever hit is low.
    always_comb begin
        hit    = 1'b0;
        msg_no = 4'd0;
        if (msgcode == MSGCODE_RDI_REQ) begin
            case (subcode)
                SUB_ACTIVE:    begin hit = 1'b1; msg_no = 4'd1; end
                SUB_L1:        begin hit = 1'b1; msg_no = 4'd2; end
                SUB_L2:        begin hit = 1'b1; msg_no = 4'd3; end
                SUB_LINKRESET: begin hit = 1'b1; msg_no = 4'd4; end
                SUB_LINKERROR: begin hit = 1'b1; msg_no = 4'd5; end
                SUB_RETRAIN:   begin hit = 1'b1; msg_no = 4'd6; end
                SUB_DISABLE:   begin hit = 1'b1; msg_no = 4'd7; end
                default:       begin hit = 1'b0; msg_no = 4'd0; end
            endcase
        end else if (msgcode == MSGCODE_RDI_RSP) begin
            case (subcode)
                SUB_ACTIVE:    begin hit = 1'b1; msg_no = 4'd8;  end
                SUB_PMNAK:     begin hit = 1'b1; msg_no = 4'd9;  end
                SUB_L1:        begin hit = 1'b1; msg_no = 4'd10; end
                SUB_L2:        begin hit = 1'b1; msg_no = 4'd11; end
                SUB_LINKRESET: begin hit = 1'b1; msg_no = 4'd12; end
                SUB_LINKERROR: begin hit = 1'b1; msg_no = 4'd13; end
                SUB_RETRAIN:   begin hit = 1'b1; msg_no = 4'd14; end
                SUB_DISABLE:   begin hit = 1'b1; msg_no = 4'd15; end
                default:       begin hit = 1'b0; msg_no = 4'd0;  end
            endcase
        end else begin
            hit    = 1'b0;
            msg_no = 4'd0;
        end
    end

endmodule

// File: rtl/sb_rdi_decoder.sv
// RX sideband decoder: pops FWFT FIFO words, turns RDI packets into message
// numbers, replays other packets as credit-gated pl_cfg phases, drops illegal ones.
module sb_rdi_decoder
    import sb_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CRD_W   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_fifo_data,
    input  logic        i_fifo_empty,
    output logic        o_fifo_read_en,
    output logic [31:0] o_pl_cfg,
    output logic        o_pl_cfg_vld,
    output logic        o_rising_edge_pl_cfg_vld,
    input  logic        i_lp_cfg_crd,
    output logic [3:0]  o_msg_no,
    output logic        o_msg_valid,
    output logic        o_error
);

    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);
    localparam logic [CRD_W-1:0] CRD_ONE  = {{(CRD_W-1){1'b0}}, 1'b1};
    localparam logic [CRD_W-1:0] CRD_ZERO = {CRD_W{1'b0}};

    rdi_dec_state_e   state_r;
    rdi_dec_state_e   next_state_s;
    logic [63:0]      hdr_r;
    logic [63:0]      data_r;
    logic [63:0]      hdr_nxt_s;
    logic [63:0]      data_nxt_s;
    logic             is_data_r;
    logic [CRD_W-1:0] credit_r;
    logic             credit_avail_s;
    logic             crd_inc_s;
    logic [4:0]       opcode_s;
    logic [7:0]       msgcode_s;
    logic [7:0]       subcode_s;
    logic             lut_hit_s;
    logic [3:0]       lut_msg_s;
    pkt_class_e       pkt_class_s;
    logic             hdr_pop_s;
    logic             data_pop_s;
    logic             msg_pop_s;
    logic             err_pop_s;
    logic [31:0]      cfg_s;
    logic             vld_s;
    logic             rise_s;

    assign opcode_s       = hdr_opcode(i_fifo_data);
    assign msgcode_s      = hdr_msgcode(i_fifo_data);
    assign subcode_s      = hdr_subcode(i_fifo_data);
    assign pkt_class_s    = classify(i_fifo_empty, opcode_s, msgcode_s, lut_hit_s);
    assign credit_avail_s = (credit_r != CRD_ZERO);
    assign o_fifo_read_en = hdr_pop_s | data_pop_s | msg_pop_s | err_pop_s;

    sb_rdi_msg_lut u_msg_lut (
        .msgcode (msgcode_s),
        .subcode (subcode_s),
        .hit     (lut_hit_s),
        .msg_no  (lut_msg_s)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and pop decisions; every pop is qualified by a non-empty FIFO.
    always_comb begin
        next_state_s = state_r;
        hdr_pop_s    = 1'b0;
        data_pop_s   = 1'b0;
        msg_pop_s    = 1'b0;
        err_pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                case (pkt_class_s)
                    CLS_RDI:     msg_pop_s = 1'b1;
                    CLS_ILLEGAL: err_pop_s = 1'b1;
                    CLS_NODATA: begin
                        if (credit_avail_s) begin
                            hdr_pop_s    = 1'b1;
                            next_state_s = ST_HDR_PH0;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
                    end
                    CLS_DATA: begin
                        if (credit_avail_s) begin
                            hdr_pop_s    = 1'b1;
                            next_state_s = ST_FETCH_DATA;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
                    end
                    default: next_state_s = ST_IDLE;
                endcase
            end
            ST_FETCH_DATA: begin
                if (!i_fifo_empty) begin
                    data_pop_s   = 1'b1;
                    next_state_s = ST_HDR_PH0;
                end else begin
                    next_state_s = ST_FETCH_DATA;
                end
            end
            ST_HDR_PH0: next_state_s = ST_HDR_PH1;
            ST_HDR_PH1: begin
                if (is_data_r) begin
                    next_state_s = ST_DAT_PH0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DAT_PH0: next_state_s = ST_DAT_PH1;
            ST_DAT_PH1: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the state and buffers they will hold next cycle.
    assign hdr_nxt_s  = hdr_pop_s  ? i_fifo_data : hdr_r;
    assign data_nxt_s = data_pop_s ? i_fifo_data : data_r;

    // Phase output decode for the upcoming state.
    always_comb begin
        cfg_s  = 32'd0;
        vld_s  = 1'b0;
        rise_s = 1'b0;
        case (next_state_s)
            ST_HDR_PH0: begin vld_s = 1'b1; rise_s = 1'b1; cfg_s = hdr_nxt_s[31:0];  end
            ST_HDR_PH1: begin vld_s = 1'b1; cfg_s = hdr_nxt_s[63:32]; end
            ST_DAT_PH0: begin vld_s = 1'b1; cfg_s = data_nxt_s[31:0];  end
            ST_DAT_PH1: begin vld_s = 1'b1; cfg_s = data_nxt_s[63:32]; end
            default:    begin vld_s = 1'b0; rise_s = 1'b0; cfg_s = 32'd0; end
        endcase
    end

    // Header and data word buffers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hdr_r     <= 64'd0;
            data_r    <= 64'd0;
            is_data_r <= 1'b0;
        end else begin
            if (hdr_pop_s) begin
                hdr_r     <= i_fifo_data;
                is_data_r <= (pkt_class_s == CLS_DATA);
            end
            if (data_pop_s) begin
                data_r <= i_fifo_data;
            end
        end
    end

    // A return at full count is dropped unless a header pop consumes a credit in the same cycle.
    assign crd_inc_s = i_lp_cfg_crd && ((credit_r != CRD_MAX) || hdr_pop_s);

    // Adapter credit counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            credit_r <= CRD_MAX;
        end else if (hdr_pop_s && !crd_inc_s) begin
            credit_r <= credit_r - CRD_ONE;
        end else if (!hdr_pop_s && crd_inc_s) begin
            credit_r <= credit_r + CRD_ONE;
        end else begin
            credit_r <= credit_r;
        end
    end

    // Registered outputs toward the adapter and the RDI FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pl_cfg                 <= 32'd0;
            o_pl_cfg_vld             <= 1'b0;
            o_rising_edge_pl_cfg_vld <= 1'b0;
            o_msg_no                 <= 4'd0;
            o_msg_valid              <= 1'b0;
            o_error                  <= 1'b0;
        end else begin
            o_pl_cfg                 <= cfg_s;
            o_pl_cfg_vld             <= vld_s;
            o_rising_edge_pl_cfg_vld <= rise_s;
            o_msg_no                 <= msg_pop_s ? lut_msg_s : 4'd0;
            o_msg_valid              <= msg_pop_s;
            o_error                  <= err_pop_s;
        end
    end

endmodule

// File: tb/tb_sb_rdi_decoder.sv
// Scoreboard bench for sb_rdi_decoder: a FWFT FIFO model feeds the DUT, expected
// responses are queued at stimulus time and a negedge monitor compares them.
module tb_sb_rdi_decoder;

    localparam int K_MSG = 0;
    localparam int K_ERR = 1;
    localparam int K_PH  = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
        bit          first;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fifo_data;
    logic        fifo_empty;
    logic        read_en;
    logic [31:0] pl_cfg;
    logic        pl_cfg_vld;
    logic        rise;
    logic        crd;
    logic [3:0]  msg_no;
    logic        msg_valid;
    logic        err;

    exp_t        exp_q[$];
    logic [63:0] fifo_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          do_pop   = 1'b0;
    bit          prev_vld = 1'b0;
    bit          popped_last = 1'b0;
    bit          auto_crd = 1'b0;
    int          owed = 0;
    int          done = 0;

    always #5 clk = ~clk;

    sb_rdi_decoder #(.CREDITS(4), .CRD_W(3)) dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_fifo_data              (fifo_data),
        .i_fifo_empty             (fifo_empty),
        .o_fifo_read_en           (read_en),
        .o_pl_cfg                 (pl_cfg),
        .o_pl_cfg_vld             (pl_cfg_vld),
        .o_rising_edge_pl_cfg_vld (rise),
        .i_lp_cfg_crd             (crd),
        .o_msg_no                 (msg_no),
        .o_msg_valid              (msg_valid),
        .o_error                  (err)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 64'd0 : fifo_q[0];
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [7:0] mc, input logic [7:0] sc);
        return {24'h0, sc, 10'h0, mc, 9'h0, op};
    endfunction

    // Reference RDI table: position in the listed subcodes gives the message number.
    function automatic int rdi_msg(input logic [7:0] mc, input logic [7:0] sc);
        logic [7:0] req_tab [7] = '{8'h01, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        logic [7:0] rsp_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        int res;
        res = 0;
        if (mc == 8'h01) begin
            for (int i = 0; i < 7; i++) if (req_tab[i] == sc) res = i + 1;
        end else if (mc == 8'h02) begin
            for (int i = 0; i < 8; i++) if (rsp_tab[i] == sc) res = i + 8;
        end
        return res;
    endfunction

    function automatic void push_exp(input int kind, input logic [31:0] val, input bit first, input bit last);
        exp_t e;
        e.kind = kind; e.val = val; e.first = first; e.last = last;
        exp_q.push_back(e);
    endfunction

    // Expected DUT response to one packet, from the header rules alone.
    function automatic void expect_pkt(input logic [63:0] hdr, input logic [63:0] dat);
        logic [4:0] op;
        logic [7:0] mc;
        int m;
        op = hdr[4:0];
        mc = hdr[21:14];
        if (op == 5'b10010 && (mc == 8'h01 || mc == 8'h02)) begin
            m = rdi_msg(mc, hdr[39:32]);
            if (m > 0) push_exp(K_MSG, 32'(m), 1'b1, 1'b1);
            else push_exp(K_ERR, 32'd0, 1'b1, 1'b1);
        end else if (op == 5'b10010) begin
            push_exp(K_PH, hdr[31:0], 1'b1, 1'b0);
            push_exp(K_PH, hdr[63:32], 1'b0, 1'b1);
        end else if (op == 5'b11011) begin
            push_exp(K_PH, hdr[31:0], 1'b1, 1'b0);
            push_exp(K_PH, hdr[63:32], 1'b0, 1'b0);
            push_exp(K_PH, dat[31:0], 1'b0, 1'b0);
            push_exp(K_PH, dat[63:32], 1'b0, 1'b1);
        end else begin
            push_exp(K_ERR, 32'd0, 1'b1, 1'b1);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic pulse_crd(input int n);
        repeat (n) begin
            crd = 1'b1;
            tick();
        end
        crd = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check({"drain_", tag}, 64'(exp_q.size() == 0 && fifo_q.size() == 0), 64'd1);
        repeat (3) tick();
    endtask

    // FIFO model: apply the pop the monitor sampled, then present the new head.
    always begin
        @(posedge clk);
        #1;
        if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    end

    // Adapter model: returns one credit per completed packet after a random delay.
    always begin
        @(posedge clk);
        #1;
        if (auto_crd) begin
            if (owed > done && $urandom_range(0, 2) != 0) begin
                crd = 1'b1;
                done++;
            end else begin
                crd = 1'b0;
            end
        end
    end

    // Monitor: compare every DUT output event against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            do_pop = 1'b0; prev_vld = 1'b0; popped_last = 1'b0;
        end else begin
            if (read_en) check("pop_when_empty", 64'(fifo_empty), 64'd0);
            if (msg_valid) begin
                if (exp_q.size() == 0) check("unexpected_msg", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("msg_kind", 64'(e.kind), 64'(K_MSG));
                    check("msg_no", 64'(msg_no), 64'(e.val));
                    check("msg_latency", 64'(popped_last), 64'd1);
                end
            end
            if (err) begin
                if (exp_q.size() == 0) check("unexpected_err", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("err_kind", 64'(e.kind), 64'(K_ERR));
                    check("err_latency", 64'(popped_last), 64'd1);
                end
            end
            if (pl_cfg_vld) begin
                if (exp_q.size() == 0) check("unexpected_vld", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("ph_kind", 64'(e.kind), 64'(K_PH));
                    check("pl_cfg", 64'(pl_cfg), 64'(e.val));
                    check("rise", 64'(rise), 64'(e.first));
                    if (e.first) check("ph_latency", 64'(popped_last), 64'd1);
                    else check("contiguous", 64'(prev_vld), 64'd1);
                    if (e.last && auto_crd) owed++;
                end
            end else if (rise) begin
                check("stray_rise", 64'd1, 64'd0);
            end
            prev_vld    = pl_cfg_vld;
            popped_last = read_en;
            do_pop      = read_en;
        end
    end

    initial begin
        logic [63:0] w;
        logic [63:0] dw;
        int kind;
        int k;

        rst = 1'b1;
        crd = 1'b0;
        refresh();
        #12;
        check("rst_read_en", 64'(read_en), 64'd0);
        check("rst_vld", 64'(pl_cfg_vld), 64'd0);
        check("rst_pl_cfg", 64'(pl_cfg), 64'd0);
        check("rst_msg_valid", 64'(msg_valid), 64'd0);
        check("rst_error", 64'(err), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // RDI request and response, then two back-to-back RDI words.
        w = mk_hdr(5'b10010, 8'h01, 8'h0B); expect_pkt(w, 64'd0); push_word(w);
        wait_drain("rdi_req");
        w = mk_hdr(5'b10010, 8'h02, 8'h02); expect_pkt(w, 64'd0); push_word(w);
        wait_drain("rdi_rsp");
        w = mk_hdr(5'b10010, 8'h01, 8'h01); expect_pkt(w, 64'd0); push_word(w);
        w = mk_hdr(5'b10010, 8'h02, 8'h0C); expect_pkt(w, 64'd0); push_word(w);
        wait_drain("rdi_b2b");

        // NODATA packet (msgcode 04), then return its credit.
        w = 64'h00060000_00010012; expect_pkt(w, 64'd0); push_word(w);
        wait_drain("nodata");
        pulse_crd(1);

        // DATA packet whose data word arrives three cycles after the header.
        w  = 64'h00000000_0000001B;
        dw = 64'hCAFEBABE_DEADBEEF;
        expect_pkt(w, dw);
        push_word(w);
        repeat (3) begin
            tick();
            check("data_wait_vld", 64'(pl_cfg_vld), 64'd0);
        end
        push_word(dw);
        wait_drain("data");
        pulse_crd(1);

        // Illegal packets: bad opcode, unlisted request subcodes.
        w = 64'h00000000_0000001F; expect_pkt(w, 64'd0); push_word(w);
        w = 64'h00000005_00004012; expect_pkt(w, 64'd0); push_word(w);
        w = 64'h00060000_00004012; expect_pkt(w, 64'd0); push_word(w);
        wait_drain("illegal");

        // Credit exhaustion: four go, the fifth waits for a returned credit.
        for (int i = 0; i < 5; i++) begin
            w = mk_hdr(5'b10010, 8'h20 + 8'(i), 8'h30 + 8'(i));
            expect_pkt(w, 64'd0);
            push_word(w);
        end
        repeat (30) tick();
        check("exhaust_fifo_left", 64'(fifo_q.size()), 64'd1);
        check("exhaust_exp_left", 64'(exp_q.size()), 64'd2);
        pulse_crd(1);
        wait_drain("exhaust_release");

        // Simultaneous pop and return at count 1 keeps the count at 1.
        pulse_crd(1);
        w = mk_hdr(5'b10010, 8'h40, 8'h00); expect_pkt(w, 64'd0); push_word(w);
        crd = 1'b1;
        tick();
        crd = 1'b0;
        wait_drain("simul");
        w = mk_hdr(5'b10010, 8'h41, 8'h00); expect_pkt(w, 64'd0); push_word(w);
        wait_drain("simul_after");
        w = mk_hdr(5'b10010, 8'h42, 8'h00); expect_pkt(w, 64'd0); push_word(w);
        repeat (15) tick();
        check("simul_blocked", 64'(fifo_q.size()), 64'd1);
        pulse_crd(1);
        wait_drain("simul_release");

        // Saturation: five returns from zero leave exactly four credits.
        pulse_crd(5);
        for (int i = 0; i < 5; i++) begin
            w = mk_hdr(5'b10010, 8'h50 + 8'(i), 8'h00);
            expect_pkt(w, 64'd0);
            push_word(w);
        end
        repeat (30) tick();
        check("sat_fifo_left", 64'(fifo_q.size()), 64'd1);
        pulse_crd(1);
        wait_drain("sat_release");
        pulse_crd(4);

        // Randomized traffic with an adapter that returns credits.
        auto_crd = 1'b1;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 4);
            w  = {$urandom, $urandom};
            dw = {$urandom, $urandom};
            case (kind)
                0: begin
                    w[4:0] = 5'b10010;
                    w[21:14] = 8'($urandom_range(1, 2));
                    w[39:32] = (w[21:14] == 8'h01) ? 8'h08 + 8'($urandom_range(0, 4)) : 8'($urandom_range(1, 2));
                end
                1: begin
                    w[4:0] = 5'b10010;
                    w[21:14] = 8'($urandom_range(1, 2));
                    w[39:32] = 8'($urandom_range(0, 15));
                end
                2: begin
                    w[4:0] = 5'b10010;
                    w[21:14] = 8'($urandom_range(3, 255));
                end
                3: w[4:0] = 5'b11011;
                default: begin
                    while (w[4:0] == 5'b10010 || w[4:0] == 5'b11011) w[4:0] = 5'($urandom);
                end
            endcase
            expect_pkt(w, dw);
            k = 0;
            while (fifo_q.size() > 6 && k < 100) begin tick(); k++; end
            push_word(w);
            if (w[4:0] == 5'b11011) begin
                repeat ($urandom_range(0, 3)) tick();
                push_word(dw);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain("random");
        k = 0;
        while (done != owed && k < 100) begin tick(); k++; end
        check("random_credits_returned", 64'(done == owed), 64'd1);
        repeat (2) tick();
        auto_crd = 1'b0;
        crd = 1'b0;
        tick();

        // Reset in the middle of a DATA packet.
        w = mk_hdr(5'b11011, 8'h77, 8'h55);
        dw = {$urandom, $urandom};
        expect_pkt(w, dw);
        push_word(w);
        push_word(dw);
        k = 0;
        while (!rise && k < 50) begin tick(); k++; end
        check("rise_before_reset", 64'(rise), 64'd1);
        tick();
        tick();
        check("dat_ph0_vld", 64'(pl_cfg_vld), 64'd1);
        check("dat_ph0_cfg", 64'(pl_cfg), 64'(dw[31:0]));
        rst = 1'b1;
        exp_q.delete();
        fifo_q.delete();
        refresh();
        #1;
        check("mid_rst_vld", 64'(pl_cfg_vld), 64'd0);
        check("mid_rst_pl_cfg", 64'(pl_cfg), 64'd0);
        check("mid_rst_rise", 64'(rise), 64'd0);
        check("mid_rst_read_en", 64'(read_en), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            w = mk_hdr(5'b10010, 8'h60 + 8'(i), 8'h00);
            expect_pkt(w, 64'd0);
            push_word(w);
        end
        repeat (30) tick();
        check("post_rst_fifo_left", 64'(fifo_q.size()), 64'd1);
        check("post_rst_exp_left", 64'(exp_q.size()), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
